pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the ALU-result and store-data fields.
REQ-002 Parameter DEST_W, default 5, width of the destination-register field.
REQ-003 Parameter CTRL_W, default 4, width of the control vector {mem_to_reg, reg_write, mem_write, mem_read}, MSB first.
REQ-004 Parameter SKID, default 1; 1 selects the two-entry skid mode, 0 selects the single-entry mode.
REQ-005 clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 flush  input  1  synchronous kill of all held entries (bubble insertion).
REQ-008 in_valid  input  1  upstream offers an entry.
REQ-009 in_ready  output  1  stage accepts the entry this cycle.
REQ-010 in_ctrl, in_alu_res, in_rt, in_dest  input  CTRL_W/DATA_W/DATA_W/DEST_W  upstream payload.
REQ-011 out_valid  output  1  stage presents an entry.
REQ-012 out_ready  input  1  downstream consumes the entry this cycle.
REQ-013 out_ctrl, out_address, out_rt, out_dest  output  CTRL_W/DATA_W/DATA_W/DEST_W  presented payload.

Function
REQ-014 An input transfer (in_fire) occurs on a rising edge where in_valid and in_ready are both 1; an output transfer (out_fire) occurs where out_valid and out_ready are both 1.
REQ-015 When SKID=1, the stage holds a main slot and a skid slot, and its FSM has the states EMPTY, ONE and TWO.
REQ-016 When SKID=1, in_ready is a registered signal equal to (state != TWO), with no combinational path from out_ready.
REQ-017 In EMPTY, in_fire loads the main slot and moves the FSM to ONE.
REQ-018 In ONE, in_fire with out_fire loads the main slot and the FSM stays in ONE.
REQ-019 In ONE, in_fire without out_fire loads the skid slot and moves the FSM to TWO.
REQ-020 In ONE, out_fire without in_fire moves the FSM to EMPTY.
REQ-021 In TWO, out_fire copies the skid slot to the main slot and moves the FSM to ONE; otherwise the FSM holds.
REQ-022 When SKID=0, the stage holds a single slot, and in_ready = !out_valid || out_ready (combinational).
REQ-023 The outputs are driven from the main slot, and out_valid = (state != EMPTY).
REQ-024 Entries leave in acceptance order, with one-cycle latency from in_fire to out_valid when the stage is empty.
REQ-025 While out_valid=0, out_ctrl is forced to all zeros so that downstream sees a bubble; the data outputs hold their last value.
REQ-026 flush has priority over every transfer in the same cycle: the FSM moves to EMPTY, both slots are invalidated, and a coincident in_valid entry is dropped.
REQ-027 A held entry that is not consumed keeps all of its payload bits unchanged across the cycles it is held.

Reset
REQ-028 Asserting rst low immediately and asynchronously sets the state to EMPTY, out_valid to 0, in_ready to 0 and all payload outputs to 0.
REQ-029 Releasing rst makes in_ready equal to 1 at the first rising clk edge after release.
REQ-030 Asserting reset mid-transfer discards all held entries, and no partial entry is presented after reset.

Structure
REQ-031 A shared package pipe_pkg holds the state enumeration (EMPTY/ONE/TWO), the default widths and the control-bit index constants.
REQ-032 One sub-module, pipe_slot, implements a single enable-loaded payload register with asynchronous reset; it is instantiated once or twice according to SKID.

Verification
REQ-033 Reset then streaming: 4 entries with in_dest=1..4, out_ready=1 -> out_dest shows 1,2,3,4 on consecutive cycles with one-cycle latency.
REQ-034 Backpressure: out_ready=0 while 3 entries are offered -> 2 entries are accepted and in_ready=0 from the next cycle; after out_ready=1 the entries drain in order with no duplicates.
REQ-035 Flush collision: state TWO plus flush=1 plus in_valid=1 -> the next cycle has out_valid=0, out_ctrl=4'b0000, and the dropped entry never appears.
REQ-036 Bubble control: idle stage holding ctrl 4'b0110 -> out_ctrl=4'b0000 while out_valid=0.
REQ-037 SKID=0 build: out_ready toggling every cycle with in_valid=1 -> in_ready follows out_ready combinationally and entries stay in order.
REQ-038 Asynchronous reset: rst asserted between clock edges with state ONE -> out_valid falls to 0 before the next clk edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state enum, default widths and control-bit indices for the pipe stage
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int DATA_W_DEF = 32;
    localparam int DEST_W_DEF = 5;
    localparam int CTRL_W_DEF = 4;

    // Control vector is {mem_to_reg, reg_write, mem_write, mem_read}, MSB first.
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_REG_WRITE  = 2;
    localparam int CTRL_MEM_WRITE  = 1;
    localparam int CTRL_MEM_READ   = 0;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - enable-loaded payload register with asynchronous active-low reset
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - EX/MEM style pipeline stage register with optional two-entry skid buffer
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEST_W = DEST_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_rt,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_address,
    output logic [DATA_W-1:0] out_rt,
    output logic [DEST_W-1:0] out_dest
);

    localparam int PAY_W = CTRL_W + 2 * DATA_W + DEST_W;

    pipe_state_e      state;
    pipe_state_e      state_nxt;
    logic             in_fire;
    logic             out_fire;
    logic             main_load;
    logic             skid_load;
    logic             main_from_skid;
    logic             ready_q;
    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] main_d;
    logic [PAY_W-1:0] main_q;
    logic [PAY_W-1:0] skid_q;

    assign in_pay    = {in_ctrl, in_alu_res, in_rt, in_dest};
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // ready_q is low in reset; the skid build exposes it directly so in_ready never depends on out_ready.
    assign in_ready = (SKID != 0) ? ready_q : (ready_q && (!out_valid || out_ready));

    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire && (SKID != 0)) begin
                        skid_load = 1'b1;
                        state_nxt = TWO;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        state_nxt      = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != TWO);
        end
    end

    assign main_d = main_from_skid ? skid_q : in_pay;

    pipe_slot #(.W(PAY_W)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    if (SKID != 0) begin : g_skid
        pipe_slot #(.W(PAY_W)) u_skid (
            .clk  (clk),
            .rst  (rst),
            .load (skid_load),
            .d    (in_pay),
            .q    (skid_q)
        );
    end else begin : g_no_skid
        assign skid_q = '0;
    end

    // Control is squashed while empty so a stale entry is seen downstream as a bubble.
    assign out_ctrl    = out_valid ? main_q[DEST_W+2*DATA_W +: CTRL_W] : '0;
    assign out_address = main_q[DEST_W+DATA_W +: DATA_W];
    assign out_rt      = main_q[DEST_W +: DATA_W];
    assign out_dest    = main_q[DEST_W-1:0];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg, skid and single-entry builds
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [4:0]  dest;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    ent_t        in_e = '0;
    logic        in_ready, out_valid;
    logic [3:0]  out_ctrl;
    logic [31:0] out_address, out_rt;
    logic [4:0]  out_dest;

    logic        in_valid0 = 1'b0;
    logic        out_ready0 = 1'b0;
    ent_t        in_e0 = '0;
    logic        in_ready0, out_valid0;
    logic [3:0]  out_ctrl0;
    logic [31:0] out_address0, out_rt0;
    logic [4:0]  out_dest0;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pipe_stage_reg #(.DATA_W(32), .DEST_W(5), .CTRL_W(4), .SKID(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_e.ctrl), .in_alu_res(in_e.alu), .in_rt(in_e.rt), .in_dest(in_e.dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_address(out_address), .out_rt(out_rt), .out_dest(out_dest)
    );

    pipe_stage_reg #(.DATA_W(32), .DEST_W(5), .CTRL_W(4), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .in_ctrl(in_e0.ctrl), .in_alu_res(in_e0.alu), .in_rt(in_e0.rt), .in_dest(in_e0.dest),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_ctrl(out_ctrl0), .out_address(out_address0), .out_rt(out_rt0), .out_dest(out_dest0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic ent_t mk(input logic [3:0] c, input int d);
        ent_t e;
        e.ctrl = c;
        e.alu  = 32'(d * 100 + 7);
        e.rt   = ~32'(d);
        e.dest = 5'(d);
        return e;
    endfunction

    // Reference model: a FIFO of accepted entries with capacity 2 (skid) or 1 (single).
    ent_t mq[$];
    ent_t mq0[$];
    ent_t m_last, m_last0;
    bit   m_rdy, m_run0;
    int   acc0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete(); mq0.delete();
            m_last = '0; m_last0 = '0;
            m_rdy = 0; m_run0 = 0; acc0 = 0;
        end else begin
            bit ifire, ofire, ifire0, ofire0;
            ifire  = in_valid && m_rdy;
            ofire  = (mq.size() != 0) && out_ready;
            if (flush) mq.delete();
            else begin
                if (ofire) void'(mq.pop_front());
                if (ifire) mq.push_back(in_e);
            end
            m_rdy = (mq.size() < 2);
            if (mq.size() != 0) m_last = mq[0];

            ifire0 = in_valid0 && m_run0 && ((mq0.size() == 0) || out_ready0);
            ofire0 = (mq0.size() != 0) && out_ready0;
            if (ofire0) void'(mq0.pop_front());
            if (ifire0) begin mq0.push_back(in_e0); acc0++; end
            m_run0 = 1;
            if (mq0.size() != 0) m_last0 = mq0[0];
        end
    end

    logic [4:0] got[$];
    int         got_cyc[$];
    logic [4:0] got0[$];

    always @(negedge clk) begin
        if (rst) begin
            ent_t e;
            bit   v;
            v = (mq.size() != 0);
            e = v ? mq[0] : m_last;
            chk("in_ready",    64'(in_ready),    64'(m_rdy));
            chk("out_valid",   64'(out_valid),   64'(v));
            chk("out_ctrl",    64'(out_ctrl),    64'(v ? e.ctrl : 4'b0000));
            chk("out_address", 64'(out_address), 64'(e.alu));
            chk("out_rt",      64'(out_rt),      64'(e.rt));
            chk("out_dest",    64'(out_dest),    64'(e.dest));
            v = (mq0.size() != 0);
            e = v ? mq0[0] : m_last0;
            chk("in_ready0",   64'(in_ready0),   64'(m_run0 && (!v || out_ready0)));
            chk("out_valid0",  64'(out_valid0),  64'(v));
            chk("out_ctrl0",   64'(out_ctrl0),   64'(v ? e.ctrl : 4'b0000));
            chk("out_dest0",   64'(out_dest0),   64'(e.dest));
            chk("out_rt0",     64'(out_rt0),     64'(e.rt));
            if (out_valid && out_ready) begin got.push_back(out_dest); got_cyc.push_back(cyc); end
            if (out_valid0 && out_ready0) got0.push_back(out_dest0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int c0;

        // Reset state
        #7;
        chk("rst_in_ready",  64'(in_ready),  64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_dest",  64'(out_dest),  64'(0));
        chk("rst_in_ready0", 64'(in_ready0), 64'(0));
        step();
        rst = 1'b1;
        step();
        chk("ready_after_release", 64'(in_ready), 64'(1));

        // Streaming, one-cycle latency
        got.delete(); got_cyc.delete();
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_e = mk(4'b1010, i);
            step();
        end
        in_valid = 1'b0;
        in_e = '0;
        repeat (3) step();
        chk("stream_count", 64'(got.size()), 64'(4));
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk("stream_dest", 64'(got[i]), 64'(i + 1));
            chk("stream_cyc",  64'(got_cyc[i]), 64'(c0 + 1 + i));
        end

        // Backpressure: two accepted, third stalls, then drain in order
        got.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_e = mk(4'b0101, 11);
        step();
        in_e = mk(4'b0101, 12);
        step();
        in_e = mk(4'b0101, 13);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        chk("bp_head_dest",    64'(out_dest), 64'(11));
        step();
        step();
        step();
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        in_e = '0;
        repeat (3) step();
        chk("bp_count", 64'(got.size()), 64'(3));
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk("bp_order", 64'(got[i]), 64'(11 + i));

        // Flush collision in TWO
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_e = mk(4'b1100, 21);
        step();
        in_e = mk(4'b1100, 22);
        step();
        flush = 1'b1;
        in_e = mk(4'b1100, 23);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        in_e = '0;
        @(negedge clk);
        chk("flush_valid", 64'(out_valid), 64'(0));
        chk("flush_ctrl",  64'(out_ctrl),  64'(0));
        chk("flush_hold",  64'(out_dest),  64'(21));
        got.delete();
        out_ready = 1'b1;
        repeat (4) step();
        chk("flush_nothing_out", 64'(got.size()), 64'(0));

        // Bubble control
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_e = mk(4'b0110, 30);
        step();
        in_valid = 1'b0;
        in_e = '0;
        @(negedge clk);
        chk("bubble_live_ctrl", 64'(out_ctrl), 64'(4'b0110));
        step();
        out_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("bubble_valid", 64'(out_valid), 64'(0));
        chk("bubble_ctrl",  64'(out_ctrl),  64'(0));
        chk("bubble_hold",  64'(out_dest),  64'(30));

        // Asynchronous reset with an entry held
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_e = mk(4'b1001, 9);
        step();
        in_valid = 1'b0;
        in_e = '0;
        @(negedge clk);
        chk("ar_held", 64'(out_valid), 64'(1));
        #1 rst = 1'b0;
        #1;
        chk("ar_valid",    64'(out_valid), 64'(0));
        chk("ar_in_ready", 64'(in_ready),  64'(0));
        chk("ar_dest",     64'(out_dest),  64'(0));
        chk("ar_address",  64'(out_address), 64'(0));
        step();
        rst = 1'b1;
        got.delete();
        out_ready = 1'b1;
        step();
        chk("ar_ready_back", 64'(in_ready), 64'(1));
        repeat (3) step();
        chk("ar_no_stale", 64'(got.size()), 64'(0));

        // Single-entry build with toggling out_ready
        got0.delete();
        in_valid0 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            out_ready0 = (k % 2 == 0);
            in_e0 = mk(4'b0011, 24 + acc0);
            #1;
            if (k > 0) chk("s0_ready_follows", 64'(in_ready0), 64'(out_ready0));
            step();
        end
        in_valid0 = 1'b0;
        in_e0 = '0;
        out_ready0 = 1'b1;
        repeat (3) step();
        chk("s0_count", 64'(got0.size()), 64'(6));
        for (int i = 0; i < got0.size(); i++)
            chk("s0_order", 64'(got0[i]), 64'(24 + i));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
